axi_read_arbiter: RTL and testbench

- Shares the single AXI read channel (AR/R) of the CPU bus interface between the instruction cache and the data cache read masters.
- Grants one master at a time and forwards its AR request downstream.
- Steers all R beats back to the granted master until the last beat (RLAST), then re-arbitrates.
- Sits between the two cache controllers and the AXI crossbar/bridge; at most one read transaction outstanding.

---
 rtl/axi_read_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_read_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-channel arbiter (icache / dcache), one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN to alternate tie priority instead of fixed dcache-first.
module axi_read_arbiter #(
  parameter logic [3:0]  IC_ARID = 4'd0,
  parameter logic [3:0]  DC_ARID = 4'd1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_araddr,
  input  logic [7:0]        ic_arlen,
  input  logic [2:0]        ic_arsize,
  input  logic              ic_arvalid,
  output logic              ic_arready,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rlast,
  output logic              ic_rvalid,
  input  logic              ic_rready,
  input  logic [ADDR_W-1:0] dc_araddr,
  input  logic [7:0]        dc_arlen,
  input  logic [2:0]        dc_arsize,
  input  logic              dc_arvalid,
  output logic              dc_arready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rlast,
  output logic              dc_rvalid,
  input  logic              dc_rready,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {IDLE, AR_SEND, R_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;

  logic w_any_req, w_pick_dc, w_dc_prio, w_grant, w_in_r, w_last_hs;

  assign w_any_req = ic_arvalid | dc_arvalid;
  assign w_pick_dc = dc_arvalid & (~ic_arvalid | w_dc_prio);
  assign w_grant   = (r_state == IDLE) & w_any_req;
  assign w_in_r    = (r_state == R_WAIT);
  assign w_last_hs = m_rvalid & m_rready & m_rlast;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= 1'b0;
    end else if (w_grant) begin
      r_last_owner <= w_pick_dc;
    end
  end

  // On a tie the master that did not own the previous transaction wins.
  assign w_dc_prio = ~r_last_owner;
`else
  assign w_dc_prio = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_pick_dc;
        r_addr  <= w_pick_dc ? dc_araddr : ic_araddr;
        r_len   <= w_pick_dc ? dc_arlen  : ic_arlen;
        r_size  <= w_pick_dc ? dc_arsize : ic_arsize;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = AR_SEND;
      AR_SEND: if (m_arready) w_state_nxt = R_WAIT;
      R_WAIT:  if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // Request is consumed on the arbitration cycle; masked while reset is held.
    ic_arready = ~rst & w_grant & ~w_pick_dc;
    dc_arready = ~rst & w_grant & w_pick_dc;

    m_arvalid = (r_state == AR_SEND);
    m_arid    = r_owner ? DC_ARID : IC_ARID;
    m_araddr  = r_addr;
    m_arlen   = r_len;
    m_arsize  = r_size;
    m_arburst = (r_len != 8'd0) ? 2'b01 : 2'b00;

    m_rready  = w_in_r & (r_owner ? dc_rready : ic_rready);

    ic_rvalid = w_in_r & ~r_owner & m_rvalid;
    ic_rlast  = w_in_r & ~r_owner & m_rlast;
    ic_rdata  = (w_in_r & ~r_owner) ? m_rdata : '0;
    dc_rvalid = w_in_r & r_owner & m_rvalid;
    dc_rlast  = w_in_r & r_owner & m_rlast;
    dc_rdata  = (w_in_r & r_owner) ? m_rdata : '0;
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed scenarios then randomized two-master traffic.
module tb_axi_read_arbiter;

  localparam logic [3:0] IcId = 4'd0;
  localparam logic [3:0] DcId = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ic_araddr = '0, dc_araddr = '0;
  logic [7:0]  ic_arlen = '0, dc_arlen = '0;
  logic [2:0]  ic_arsize = '0, dc_arsize = '0;
  logic        ic_arvalid = 1'b0, dc_arvalid = 1'b0;
  logic        ic_rready = 1'b1, dc_rready = 1'b1;
  logic        ic_arready, dc_arready, ic_rlast, dc_rlast, ic_rvalid, dc_rvalid;
  logic [31:0] ic_rdata, dc_rdata;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_rready;
  logic        m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arsize(ic_arsize),
    .ic_arvalid(ic_arvalid), .ic_arready(ic_arready), .ic_rdata(ic_rdata),
    .ic_rlast(ic_rlast), .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
    .dc_araddr(dc_araddr), .dc_arlen(dc_arlen), .dc_arsize(dc_arsize),
    .dc_arvalid(dc_arvalid), .dc_arready(dc_arready), .dc_rdata(dc_rdata),
    .dc_rlast(dc_rlast), .dc_rvalid(dc_rvalid), .dc_rready(dc_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [3:0] id, input logic [31:0] addr,
                                            input int i);
    return addr + 32'(i * 4) + {id, 28'h0};
  endfunction

  // Reference model: one transaction at a time, tie-break per configured policy.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  bit    md_busy = 0, md_ar_done = 0, md_owner = 0, md_last = 0;
  int    ic_beats = 0, dc_beats = 0;

  function automatic bit dc_has_prio();
`ifdef ARB_ROUND_ROBIN_EN
    return !md_last;
`else
    return 1'b1;
`endif
  endfunction

  initial begin : monitor
    bit busy0, done0, exp_dc, own_rr, hs;
    ar_t a;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs", {m_arvalid, m_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid},
            64'h0);
        ar_q.delete();
        beat_q.delete();
        md_busy = 0; md_ar_done = 0; md_owner = 0; md_last = 0;
      end else begin
        busy0 = md_busy;
        done0 = md_ar_done;
        chk("m_arvalid", m_arvalid, busy0 && !done0);
        if (m_arvalid) begin
          if (ar_q.size() == 0) begin
            chk("ar_unexpected", 1, 0);
          end else begin
            chk("ar_fields", {m_arid, m_araddr, m_arlen, m_arsize}, ar_q[0]);
            chk("m_arburst", m_arburst, (ar_q[0].len != 0) ? 2'b01 : 2'b00);
            if (m_arready) begin
              void'(ar_q.pop_front());
              md_ar_done = 1;
            end
          end
        end
        own_rr = md_owner ? dc_rready : ic_rready;
        chk("m_rready", m_rready, (busy0 && done0) ? own_rr : 1'b0);
        chk("rvalid_steer", {ic_rvalid, dc_rvalid},
            (busy0 && done0 && m_rvalid) ? (md_owner ? 2'b01 : 2'b10) : 2'b00);
        if (busy0 && done0) chk("nonowner_rdata", md_owner ? ic_rdata : dc_rdata, 32'h0);
        hs = busy0 && done0 && m_rvalid && own_rr;
        if (hs) begin
          if (beat_q.size() == 0) begin
            chk("beat_unexpected", 1, 0);
          end else begin
            b = beat_q.pop_front();
            chk("beat", md_owner ? {dc_rdata, dc_rlast} : {ic_rdata, ic_rlast}, b);
            if (md_owner) dc_beats++; else ic_beats++;
            if (b.last) begin
              md_busy = 0;
              md_ar_done = 0;
            end
          end
        end
        if (!busy0 && (ic_arvalid || dc_arvalid)) begin
          exp_dc = dc_arvalid && (!ic_arvalid || dc_has_prio());
          chk("grant", {ic_arready, dc_arready}, {!exp_dc, exp_dc});
          a.id   = exp_dc ? DcId : IcId;
          a.addr = exp_dc ? dc_araddr : ic_araddr;
          a.len  = exp_dc ? dc_arlen : ic_arlen;
          a.size = exp_dc ? dc_arsize : ic_arsize;
          ar_q.push_back(a);
          for (int i = 0; i <= int'(a.len); i++) begin
            beat_q.push_back({beat_data(a.id, a.addr, i), i == int'(a.len)});
          end
          md_busy = 1; md_ar_done = 0; md_owner = exp_dc; md_last = exp_dc;
        end else begin
          chk("no_grant", {ic_arready, dc_arready}, 2'b00);
        end
      end
    end
  end

  // Downstream slave: random AR delay, bursts with random inter-beat gaps.
  int ar_force  = -1;
  int r_gap_max = 2;

  initial begin : slave
    bit ar_hs, r_hs, ar_seen, busy;
    int ar_cnt, beat, gap;
    logic [3:0]  sid;
    logic [31:0] saddr;
    logic [7:0]  slen;
    ar_seen = 0; busy = 0; ar_cnt = 0; beat = 0; gap = 0;
    sid = '0; saddr = '0; slen = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if (ar_hs) begin
        sid = m_arid; saddr = m_araddr; slen = m_arlen;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0;
        ar_seen = 0; busy = 0;
      end else begin
        if (ar_hs) begin
          m_arready = 0; ar_seen = 0; busy = 1; beat = 0;
          gap = $urandom_range(0, r_gap_max);
        end else if (!busy && m_arvalid) begin
          if (!ar_seen) begin
            ar_seen = 1;
            ar_cnt = (ar_force >= 0) ? ar_force : $urandom_range(0, 3);
          end
          if (ar_cnt == 0) m_arready = 1;
          else ar_cnt--;
        end
        if (busy) begin
          if (r_hs) begin
            m_rvalid = 0; m_rlast = 0;
            if (beat == int'(slen)) busy = 0;
            else begin
              beat++;
              gap = $urandom_range(0, r_gap_max);
            end
          end
          if (busy && !m_rvalid) begin
            if (gap > 0) gap--;
            else begin
              m_rvalid = 1;
              m_rdata  = beat_data(sid, saddr, beat);
              m_rlast  = (beat == int'(slen));
            end
          end
        end
      end
    end
  end

  bit rr_rand = 0;
  initial begin : rready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) begin
        ic_rready = ($urandom_range(0, 3) != 0);
        dc_rready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic req(input bit is_dc, input logic [31:0] a, input logic [7:0] l,
                     input logic [2:0] s);
    bit got;
    got = 0;
    if (is_dc) begin
      dc_araddr = a; dc_arlen = l; dc_arsize = s; dc_arvalid = 1;
    end else begin
      ic_araddr = a; ic_arlen = l; ic_arsize = s; ic_arvalid = 1;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = is_dc ? dc_arready : ic_arready;
    end
    if (!got) chk("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    // Scramble the request lines after grant: the latched copy must be used.
    if (is_dc) begin
      dc_arvalid = 0; dc_araddr = $urandom; dc_arlen = 8'($urandom);
    end else begin
      ic_arvalid = 0; ic_araddr = $urandom; ic_arlen = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      idle = !md_busy && ar_q.size() == 0 && beat_q.size() == 0 && !ic_arvalid && !dc_arvalid;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  initial begin : stimulus
    int b0, d0, cnt;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Icache alone, 8-beat burst.
    b0 = ic_beats; d0 = dc_beats;
    req(0, 32'h1FC0_0000, 8'd7, 3'd2);
    wait_idle();
    chk("ic_alone_beats", ic_beats - b0, 8);
    chk("ic_alone_dc_beats", dc_beats - d0, 0);

    // Simultaneous requests.
    fork
      req(1, 32'h8000_1000, 8'd7, 3'd2);
      req(0, 32'hBFC0_0100, 8'd7, 3'd2);
    join
    wait_idle();

    // Downstream holds arready low for 5 cycles.
    ar_force = 5;
    fork
      req(0, 32'h0000_2000, 8'd3, 3'd2);
      begin
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = m_arvalid;
        end
        cnt = 0;
        for (int i = 0; i < 50 && seen && !m_arready; i++) begin
          cnt++;
          @(negedge clk);
        end
        chk("arready_stall_cycles", cnt, 5);
      end
    join
    wait_idle();
    ar_force = -1;

    // Single uncached read with the dcache stalling rready for 3 cycles.
    r_gap_max = 0;
    dc_rready = 0;
    d0 = dc_beats;
    req(1, 32'hA000_0040, 8'd0, 3'd2);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = m_rvalid;
    end
    repeat (2) @(negedge clk);
    chk("stall_no_beat", dc_beats - d0, 0);
    @(posedge clk);
    #1 dc_rready = 1;
    wait_idle();
    chk("single_beat", dc_beats - d0, 1);

    // Reset on the fourth beat of a burst.
    b0 = ic_beats;
    req(0, 32'h1FC0_0200, 8'd7, 3'd2);
    for (int i = 0; i < 200 && ic_beats - b0 < 3; i++) @(negedge clk);
    chk("pre_reset_beats", ic_beats - b0, 3);
    #2 rst = 1;
    #1 chk("async_reset_outputs",
           {m_arvalid, m_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    b0 = ic_beats;
    req(0, 32'h1FC0_0000, 8'd1, 3'd2);
    wait_idle();
    chk("post_reset_beats", ic_beats - b0, 2);

    // Random two-master traffic, many ties.
    r_gap_max = 2;
    rr_rand = 1;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 req(0, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 req(1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
      end
    join
    rr_rand = 0;
    @(posedge clk);
    #1;
    ic_rready = 1;
    dc_rready = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
